// File: rtl/dmadd_sequencer.sv
// ---------------------------------------------------------------------------
// dmadd_sequencer
//
// Command sequencer for the delta multiply-add (DMADD) engine.
// Operand bytes arrive over a valid/ready stream and are buffered in a small
// circular FIFO. A start request replays the buffered bytes into DMADD as
// load operations, holds run high for a fixed number of cycles, waits for
// the DMADD output register to settle, then captures the 12-bit result and
// pulses done.
//
// The sequence for N operands is:
//   IDLE -> LOAD (N cycles) -> RUN (RUN_CYCLES) -> WAIT (WAIT_CYCLES)
//        -> CAPTURE (1 cycle) -> IDLE
// With an empty FIFO the LOAD phase is skipped.
//
// Every dm_* output, done and result is a register loaded from the state the
// sequencer is in, so the DMADD pins follow the state by one cycle. The pins
// therefore show N load cycles immediately followed by RUN_CYCLES run
// cycles, and result is sampled after WAIT_CYCLES cycles with run low.
//
// Parameters
//   FIFO_DEPTH   operand FIFO entries, power of two, 2..16
//   RUN_CYCLES   cycles run is held high (>= 1)
//   WAIT_CYCLES  idle cycles between the run phase and capture (>= 1)
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst_n        synchronous active-low reset
//   in_data      operand byte, [7:4] index, [3:0] data
//   in_valid     in_data valid
//   in_ready     sequencer accepts a byte (IDLE and FIFO not full)
//   start        begin a sequence, sampled in IDLE only
//   mode         DMADD instruction: 00 MIN, 01 MAX, 10 MADD, 11 reserved
//   dm_index     DMADD index
//   dm_data      DMADD data
//   dm_insn      DMADD instruction
//   dm_load      DMADD load strobe
//   dm_run       DMADD run strobe
//   dm_out       DMADD result, low byte
//   dm_out_top   DMADD result, top nibble
//   busy         high in every state except IDLE
//   done         one-cycle pulse when result is valid
//   result       captured {dm_out_top, dm_out}
//   err          sticky, set when start is sampled with mode = 11
// ---------------------------------------------------------------------------
module dmadd_sequencer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int RUN_CYCLES  = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic [3:0]  dm_index,
  output logic [3:0]  dm_data,
  output logic [1:0]  dm_insn,
  output logic        dm_load,
  output logic        dm_run,
  input  logic [7:0]  dm_out,
  input  logic [3:0]  dm_out_top,
  output logic        busy,
  output logic        done,
  output logic [11:0] result,
  output logic        err
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (RUN_CYCLES > WAIT_CYCLES) ? RUN_CYCLES : WAIT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] RUN_LAST  = TMR_W'(RUN_CYCLES - 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(WAIT_CYCLES - 1);

  localparam logic [1:0] MODE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_CAPTURE
  } state_e;

  // Control state
  state_e           state_q,    state_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0] count_q,    count_d;
  logic [TMR_W-1:0] tmr_q,      tmr_d;
  logic [1:0]       mode_q,     mode_d;

  // Registered outputs
  logic [3:0]       dm_index_q, dm_index_d;
  logic [3:0]       dm_data_q,  dm_data_d;
  logic [1:0]       dm_insn_q,  dm_insn_d;
  logic             dm_load_q,  dm_load_d;
  logic             dm_run_q,   dm_run_d;
  logic             done_q,     done_d;
  logic [11:0]      result_q,   result_d;
  logic             err_q,      err_d;

  // FIFO storage (data only, never reset)
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       head;

  logic             push;
  logic             pop;

  // Handshake and status decode from current state and FIFO occupancy
  assign in_ready = (state_q == S_IDLE) && (count_q < DEPTH_C);
  assign busy     = (state_q != S_IDLE);
  assign push     = in_valid && in_ready;
  // LOAD is only ever entered with a non-empty FIFO and leaves on the last
  // entry, so every LOAD cycle consumes exactly one entry.
  assign pop      = (state_q == S_LOAD);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    tmr_d      = tmr_q;
    mode_d     = mode_q;
    dm_index_d = dm_index_q;
    dm_data_d  = dm_data_q;
    dm_insn_d  = mode_q;
    dm_load_d  = 1'b0;
    dm_run_d   = 1'b0;
    done_d     = 1'b0;
    result_d   = result_q;
    err_d      = err_q;

    // FIFO pointer and occupancy bookkeeping
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        // Keeps DMADD's scan direction initialised while idle.
        dm_insn_d = {1'b0, mode[0]};
        if (start) begin
          if (mode == MODE_RSVD) begin
            err_d = 1'b1;
          end else begin
            mode_d = mode;
            tmr_d  = '0;
            // A byte pushed on this same edge joins the sequence, so only a
            // truly empty FIFO skips the load phase.
            if ((count_q == '0) && !push) begin
              state_d = S_RUN;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end

      S_LOAD: begin
        dm_load_d  = 1'b1;
        dm_index_d = head[7:4];
        dm_data_d  = head[3:0];
        if (count_q == ONE_C) begin
          state_d = S_RUN;
          tmr_d   = '0;
        end
      end

      S_RUN: begin
        dm_run_d = 1'b1;
        if (tmr_q == RUN_LAST) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      S_WAIT: begin
        // Gives the DMADD output register time to reflect the final run cycle.
        if (tmr_q == WAIT_LAST) begin
          state_d = S_CAPTURE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_ONE;
        end
      end

      S_CAPTURE: begin
        result_d = {dm_out_top, dm_out};
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmr_q      <= '0;
      mode_q     <= 2'b00;
      dm_index_q <= 4'h0;
      dm_data_q  <= 4'h0;
      dm_insn_q  <= 2'b00;
      dm_load_q  <= 1'b0;
      dm_run_q   <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 12'h000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tmr_q      <= tmr_d;
      mode_q     <= mode_d;
      dm_index_q <= dm_index_d;
      dm_data_q  <= dm_data_d;
      dm_insn_q  <= dm_insn_d;
      dm_load_q  <= dm_load_d;
      dm_run_q   <= dm_run_d;
      done_q     <= done_d;
      result_q   <= result_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign dm_index = dm_index_q;
  assign dm_data  = dm_data_q;
  assign dm_insn  = dm_insn_q;
  assign dm_load  = dm_load_q;
  assign dm_run   = dm_run_q;
  assign done     = done_q;
  assign result   = result_q;
  assign err      = err_q;

endmodule
